// File: rtl/dvfs_pkg.sv
// Shared types and helpers for the per-domain DVFS sequencer.
// Holds the FSM state encoding, the code widths and the V/F safety curve.
package dvfs_pkg;

    localparam int VW   = 2;
    localparam int FW   = 3;
    localparam int NDOM = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        F_DN   = 3'd1,
        V_STEP = 3'd2,
        V_WAIT = 3'd3,
        F_UP   = 3'd4,
        F_WAIT = 3'd5
    } dvfs_state_t;

    // Highest frequency code that is safe at voltage code v: 2*v+1.
    function automatic logic [FW-1:0] fmax(input logic [VW-1:0] v);
        return {v, 1'b1};
    endfunction

endpackage

// File: rtl/dvfs_domain_seq.sv
// Single-domain V/F sequencer: clamps the target onto the safety curve, then
// walks voltage one code at a time with frequency moved on the safe side.
module dvfs_domain_seq
    import dvfs_pkg::*;
#(
    parameter int             V_SETTLE = 16,
    parameter int             F_SETTLE = 4,
    parameter int             CNT_W    = 8,
    parameter logic [VW-1:0]  RST_V    = 2'b01,
    parameter logic [FW-1:0]  RST_F    = 3'b010
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [VW-1:0]   tgt_v,
    input  logic [FW-1:0]   tgt_f,
    input  logic            clr_clamp,
    output logic [VW-1:0]   v_out,
    output logic [FW-1:0]   f_out,
    output logic            busy,
    output logic            clamp_flag
);

    localparam logic [CNT_W-1:0] V_LOAD = CNT_W'(V_SETTLE - 1);
    localparam logic [CNT_W-1:0] F_LOAD = CNT_W'(F_SETTLE - 1);

    function automatic logic [FW-1:0] clamp_f(input logic [VW-1:0] v,
                                              input logic [FW-1:0] f);
        return (f > fmax(v)) ? fmax(v) : f;
    endfunction

    dvfs_state_t      state, state_nxt;
    logic [VW-1:0]    v_nxt, lv, lv_nxt, ctv;
    logic [FW-1:0]    f_nxt, lf, lf_nxt, ctf;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ret_v, ret_v_nxt, flag_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            v_out      <= RST_V;
            f_out      <= RST_F;
            lv         <= RST_V;
            lf         <= RST_F;
            cnt        <= '0;
            ret_v      <= 1'b0;
            clamp_flag <= 1'b0;
        end else begin
            state      <= state_nxt;
            v_out      <= v_nxt;
            f_out      <= f_nxt;
            lv         <= lv_nxt;
            lf         <= lf_nxt;
            cnt        <= cnt_nxt;
            ret_v      <= ret_v_nxt;
            clamp_flag <= flag_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        v_nxt     = v_out;
        f_nxt     = f_out;
        lv_nxt    = lv;
        lf_nxt    = lf;
        cnt_nxt   = cnt;
        ret_v_nxt = ret_v;
        flag_nxt  = clamp_flag & ~clr_clamp;
        ctv       = tgt_v;
        ctf       = clamp_f(tgt_v, tgt_f);

        case (state)
            IDLE: begin
                if ((ctv != v_out) || (ctf != f_out)) begin
                    lv_nxt = ctv;
                    lf_nxt = ctf;
                    // A clamp seen at sequence start beats a concurrent clear.
                    if (ctf != tgt_f)
                        flag_nxt = 1'b1;
                    if (ctf < f_out)
                        state_nxt = F_DN;
                    else if (ctv != v_out)
                        state_nxt = V_STEP;
                    else
                        state_nxt = F_UP;
                end
            end
            F_DN: begin
                f_nxt     = lf;
                cnt_nxt   = F_LOAD;
                ret_v_nxt = 1'b1;
                state_nxt = F_WAIT;
            end
            V_STEP: begin
                v_nxt     = (lv > v_out) ? v_out + 1'b1 : v_out - 1'b1;
                cnt_nxt   = V_LOAD;
                state_nxt = V_WAIT;
            end
            V_WAIT: begin
                if (cnt == '0) begin
                    if (v_out != lv)
                        state_nxt = V_STEP;
                    else if (lf > f_out)
                        state_nxt = F_UP;
                    else
                        state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            F_UP: begin
                f_nxt     = lf;
                cnt_nxt   = F_LOAD;
                ret_v_nxt = 1'b0;
                state_nxt = F_WAIT;
            end
            F_WAIT: begin
                if (cnt == '0) begin
                    if (ret_v && (v_out != lv))
                        state_nxt = V_STEP;
                    else
                        state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: rtl/dvfs_sequencer.sv
// Three-domain DVFS sequencer top: unpacks targets into core1/core2/mem
// sequencers and repacks their applied codes and status.
module dvfs_sequencer
    import dvfs_pkg::*;
#(
    parameter int             V_SETTLE = 16,
    parameter int             F_SETTLE = 4,
    parameter int             CNT_W    = 8,
    parameter logic [VW-1:0]  RST_V    = 2'b01,
    parameter logic [FW-1:0]  RST_F    = 3'b010
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NDOM*VW-1:0]   tgt_v,
    input  logic [NDOM*FW-1:0]   tgt_f,
    input  logic                 clr_clamp,
    output logic [NDOM*VW-1:0]   v_out,
    output logic [NDOM*FW-1:0]   f_out,
    output logic [NDOM-1:0]      busy,
    output logic                 all_settled,
    output logic [NDOM-1:0]      clamp_flag
);

    // Domain index 0 is mem (LSBs), 1 is core2, 2 is core1 (MSBs).
    for (genvar d = 0; d < NDOM; d++) begin : g_dom
        dvfs_domain_seq #(
            .V_SETTLE (V_SETTLE),
            .F_SETTLE (F_SETTLE),
            .CNT_W    (CNT_W),
            .RST_V    (RST_V),
            .RST_F    (RST_F)
        ) u_seq (
            .clk        (clk),
            .rst_n      (rst_n),
            .tgt_v      (tgt_v[d*VW +: VW]),
            .tgt_f      (tgt_f[d*FW +: FW]),
            .clr_clamp  (clr_clamp),
            .v_out      (v_out[d*VW +: VW]),
            .f_out      (f_out[d*FW +: FW]),
            .busy       (busy[d]),
            .clamp_flag (clamp_flag[d])
        );
    end

    assign all_settled = ~|busy;

endmodule

// File: tb/tb_dvfs_sequencer.sv
// Directed bench for dvfs_sequencer: table of target moves with hand-computed
// end states and busy lengths, plus timing, clamp, retarget and reset sequences.
module tb_dvfs_sequencer;

    localparam logic [5:0] RV = 6'b010101;
    localparam logic [8:0] RF = 9'b010010010;

    logic       clk, rst_n, clr_clamp, all_settled;
    logic [5:0] tgt_v, v_out;
    logic [8:0] tgt_f, f_out;
    logic [2:0] busy, clamp_flag;

    int n_checks = 0;
    int n_fail   = 0;
    bit inv_on   = 0;

    dvfs_sequencer u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tgt_v       (tgt_v),
        .tgt_f       (tgt_f),
        .clr_clamp   (clr_clamp),
        .v_out       (v_out),
        .f_out       (f_out),
        .busy        (busy),
        .all_settled (all_settled),
        .clamp_flag  (clamp_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] tv;
        logic [8:0] tf;
        logic [5:0] ev;
        logic [8:0] ef;
        logic [2:0] ec;
        int         ecyc;   // edges until busy==0 is observed (busy length + 1)
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_until_idle(input int limit, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (busy != 3'b000 && cyc < limit);
    endtask

    task automatic apply_reset();
        tgt_v = RV; tgt_f = RF; clr_clamp = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
    endtask

    // Safety curve and all_settled consistency every cycle.
    always @(negedge clk) begin
        if (rst_n && inv_on) begin
            for (int d = 0; d < 3; d++) begin
                n_checks++;
                if (f_out[d*3 +: 3] > {v_out[d*2 +: 2], 1'b1}) begin
                    n_fail++;
                    $display("FAIL vf_curve dom%0d: got v=%0d f=%0d", d, v_out[d*2 +: 2], f_out[d*3 +: 3]);
                end
            end
            n_checks++;
            if (all_settled !== (busy == 3'b000)) begin
                n_fail++;
                $display("FAIL all_settled: got %0b with busy=%03b", all_settled, busy);
            end
        end
    end

    initial begin
        int cyc, bsy_seen, t_b, t_v2, t_v3, t_f7, t_idle;
        bit seen_other;

        vecs[0] = '{6'b010101, 9'b010_010_010, 6'b010101, 9'b010_010_010, 3'b000, 1};
        vecs[1] = '{6'b110101, 9'b111_010_010, 6'b110101, 9'b111_010_010, 3'b000, 40};
        vecs[2] = '{6'b111111, 9'b111_111_111, 6'b111111, 9'b111_111_111, 3'b000, 40};
        vecs[3] = '{6'b000000, 9'b000_000_000, 6'b000000, 9'b000_000_000, 3'b000, 57};
        vecs[4] = '{6'b000000, 9'b000_111_000, 6'b000000, 9'b000_001_000, 3'b010, 6};
        vecs[5] = '{6'b010000, 9'b011_111_000, 6'b010000, 9'b011_001_000, 3'b010, 23};
        vecs[6] = '{6'b110000, 9'b001_111_000, 6'b110000, 9'b001_001_000, 3'b010, 40};
        vecs[7] = '{6'b110010, 9'b111_111_101, 6'b110010, 9'b111_001_101, 3'b010, 40};
        vecs[8] = '{6'b110001, 9'b111_111_110, 6'b110001, 9'b111_001_011, 3'b011, 23};

        // Reset state with arbitrary targets, then quiet release.
        rst_n = 1'b0; clr_clamp = 1'b0;
        tgt_v = 6'b111111; tgt_f = 9'h1ff;
        repeat (3) @(negedge clk);
        check("rst_v_out", v_out, RV);
        check("rst_f_out", f_out, RF);
        check("rst_busy", busy, 0);
        check("rst_all_settled", all_settled, 1);
        check("rst_clamp", clamp_flag, 0);
        tgt_v = RV; tgt_f = RF;
        @(negedge clk); rst_n = 1'b1; inv_on = 1;
        bsy_seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (busy != 0) bsy_seen++;
        end
        check("idle_no_busy", bsy_seen, 0);
        check("idle_v_out", v_out, RV);

        // Table of target moves.
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            tgt_v = vecs[k].tv; tgt_f = vecs[k].tf;
            run_until_idle(300, cyc);
            check($sformatf("vec%0d_cycles", k), cyc, vecs[k].ecyc);
            check($sformatf("vec%0d_v_out", k), v_out, vecs[k].ev);
            check($sformatf("vec%0d_f_out", k), f_out, vecs[k].ef);
            check($sformatf("vec%0d_clamp", k), clamp_flag, vecs[k].ec);
        end

        // Clamp flag clear, then set and clear in the same cycle.
        @(negedge clk); clr_clamp = 1'b1;
        @(negedge clk); clr_clamp = 1'b0;
        check("clamp_cleared", clamp_flag, 3'b000);
        @(negedge clk);
        tgt_v = 6'b110101; clr_clamp = 1'b1;
        @(negedge clk); clr_clamp = 1'b0;
        check("clamp_set_wins", clamp_flag, 3'b010);
        run_until_idle(300, cyc);
        check("clamp_core2_v", v_out[3:2], 2'd1);
        check("clamp_core2_f", f_out[5:3], 3'd3);
        check("clamp_sticky", clamp_flag, 3'b010);

        // Core1 1/2 -> 3/7 edge-by-edge timing.
        apply_reset();
        @(negedge clk);
        tgt_v = 6'b110101; tgt_f = 9'b111_010_010;
        t_b = -1; t_v2 = -1; t_v3 = -1; t_f7 = -1; t_idle = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (t_b < 0 && busy[2]) t_b = c;
            if (t_v2 < 0 && v_out[5:4] == 2'd2) t_v2 = c;
            if (t_v3 < 0 && v_out[5:4] == 2'd3) t_v3 = c;
            if (t_f7 < 0 && f_out[8:6] == 3'd7) t_f7 = c;
            if (t_idle < 0 && t_b > 0 && !busy[2]) t_idle = c;
        end
        check("t_busy_rise", t_b, 1);
        check("t_v_1to2", t_v2, 2);
        check("t_v_2to3", t_v3, 19);
        check("t_f_2to7", t_f7, 36);
        check("t_busy_fall", t_idle, 40);

        // Retarget mem while it is sequencing upward.
        apply_reset();
        @(negedge clk);
        tgt_v = 6'b010111; tgt_f = 9'b010_010_111;
        seen_other = 0;
        for (int i = 0; i < 100 && v_out[1:0] != 2'd2; i++) begin
            @(posedge clk); #1;
            if (busy[2:1] != 0) seen_other = 1;
        end
        check("mid_first_step", v_out[1:0], 2'd2);
        tgt_v = 6'b010100; tgt_f = 9'b010_010_000;
        for (int i = 0; i < 200 && busy[0]; i++) begin
            @(posedge clk); #1;
            if (busy[2:1] != 0) seen_other = 1;
        end
        check("mid_hold_v", v_out[1:0], 2'd3);
        check("mid_hold_f", f_out[2:0], 3'd7);
        @(posedge clk); #1;
        check("mid_idle_one_cycle", busy[0], 1);
        check("mid_fdn_first", f_out[2:0], 3'd7);
        run_until_idle(300, cyc);
        if (busy[2:1] != 0) seen_other = 1;
        check("mid_down_cycles", cyc, 56);
        check("mid_final_v", v_out[1:0], 2'd0);
        check("mid_final_f", f_out[2:0], 3'd0);
        check("mid_other_busy", seen_other, 0);
        check("mid_other_v", v_out[5:2], 4'b0101);
        check("mid_other_f", f_out[8:3], 6'b010_010);

        // Asynchronous reset in the middle of a voltage settle.
        apply_reset();
        @(negedge clk);
        tgt_v = 6'b110101; tgt_f = 9'b111_010_010;
        for (int i = 0; i < 100 && v_out[5:4] != 2'd2; i++) begin
            @(posedge clk); #1;
        end
        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        check("pre_arst_busy", busy, 3'b100);
        inv_on = 0;
        rst_n = 1'b0; #1;
        check("arst_v_out", v_out, RV);
        check("arst_f_out", f_out, RF);
        check("arst_busy", busy, 0);
        check("arst_all_settled", all_settled, 1);
        tgt_v = RV; tgt_f = RF;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dvfs_sequencer.md
Name: dvfs_sequencer

Overview:
- Sits directly downstream of the DPM state machine.
- Takes its per-domain target voltage/frequency codes for core1, core2 and mem, and drives the physical regulator/PLL control codes.
- Per domain it enforces safe ordering: frequency is lowered before voltage drops, voltage is raised before frequency rises. Voltage moves one code per step, with programmable settle delays.
- Targets that violate the V/F safety curve are clamped and flagged.

Parameters:
- V_SETTLE, 16, cycles to hold after each voltage step (≥1)
- F_SETTLE, 4, cycles to hold after a frequency change (≥1)
- CNT_W, 8, settle counter width; must hold max(V_SETTLE, F_SETTLE)
- RST_V, 2'b01, voltage code applied at reset (all domains)
- RST_F, 3'b010, frequency code applied at reset (all domains)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- tgt_v  in  6  target voltage codes {core1[5:4], core2[3:2], mem[1:0]}
- tgt_f  in  9  target frequency codes {core1[8:6], core2[5:3], mem[2:0]}
- clr_clamp  in  1  synchronous clear of clamp_flag (all bits)
- v_out  out  6  applied voltage codes, same packing as tgt_v
- f_out  out  9  applied frequency codes, same packing as tgt_f
- busy  out  3  per-domain sequence in progress {core1, core2, mem}
- all_settled  out  1  high when busy==0
- clamp_flag  out  3  sticky: a target was clamped, per domain

Behaviour:
- Reset:
  - Clock is clk; reset rst_n is asynchronous and active-low.
  - Every domain resets to v_out=RST_V, f_out=RST_F, state IDLE.
  - busy=0, all_settled=1, clamp_flag=0, counters=0.
  - Asserting rst_n mid-sequence aborts immediately to the reset values.
- Safety curve: f ≤ 2*v+1 (v=0→f≤1, v=1→f≤3, v=2→f≤5, v=3→f≤7).
- Clamping:
  - In IDLE, clamped target ctf = min(tgt_f, 2*tgt_v+1), ctv = tgt_v.
  - If clamping occurs while a sequence starts, clamp_flag[d] sets.
  - If clr_clamp is asserted in the same cycle, the set wins.
- Each domain runs an independent FSM. busy[d] = (state != IDLE).
  - IDLE: if (ctv,ctf) ≠ (v_out,f_out), latch lv=ctv, lf=ctf, then:
    - lf < f_out → F_DN
    - else lv ≠ v_out → V_STEP
    - else → F_UP
  - F_DN: f_out←lf; counter←F_SETTLE-1; → F_WAIT (return = V-phase).
  - V_STEP: v_out←v_out±1 toward lv; counter←V_SETTLE-1; → V_WAIT.
  - V_WAIT: decrement the counter. At 0:
    - v_out ≠ lv → V_STEP
    - else lf > f_out → F_UP
    - else → IDLE
  - F_UP: f_out←lf; counter←F_SETTLE-1; → F_WAIT (return = IDLE).
  - F_WAIT: decrement the counter. At 0:
    - return=V-phase and v_out ≠ lv → V_STEP
    - otherwise → IDLE
- Timing:
  - Action states (F_DN, V_STEP, F_UP) last exactly 1 cycle.
  - Wait states last exactly their SETTLE count.
  - Consecutive voltage changes are V_SETTLE+1 cycles apart.
  - An F_UP change follows the last voltage change by V_SETTLE+1 cycles.
- Targets are sampled only in IDLE. Changes during a sequence are ignored; the new target is re-evaluated on return to IDLE, with no cycle lost.
- Invariant at every cycle boundary: f_out ≤ 2*v_out+1 per domain.
- A mixed move (v up, f down) performs F_DN first, then the voltage steps.
- An equal target produces no activity; busy stays 0.
- Domains never interact. all_settled is the NOR of busy.
- Unused encodings of FSM state go to IDLE.

Decomposition:
- Shared package dvfs_pkg holds:
  - state enum (IDLE, F_DN, V_STEP, V_WAIT, F_UP, F_WAIT)
  - code widths VW=2, FW=3
  - function fmax(v) = 2*v+1
- One sub-module dvfs_domain_seq (single-domain FSM, counter, clamp), instantiated three times.
- The top level does packing, all_settled and the clr_clamp fan-out only.

Test Plan:
- Reset check: hold rst_n=0 with any targets → v_out=6'b010101, f_out=9'b010010010, busy=0, all_settled=1; release with tgt equal to reset → no activity for 100 cycles.
- Core1 1/2→3/7 (V_SETTLE=16, F_SETTLE=4):
  - v_out[5:4] 1→2 one cycle after detection, 2→3 17 cycles later.
  - f_out[8:6] 2→7 17 cycles after that.
  - busy[2] falls 4 cycles after the f change.
  - f ≤ 2v+1 at every cycle.
- All domains 3/7→0/0: each f_out goes to 0 on the first action cycle, then v_out steps 3→2→1→0 at 17-cycle spacing; busy clears 16 cycles after the last step.
- Clamp: tgt core2 = v=0, f=7 from reset state → core2 ends at v=0, f=1, clamp_flag[1]=1 and sticky. clr_clamp pulse → 0. Simultaneous set and clear → stays 1.
- Target change mid-sequence (mem 1→3 running, switch target to 0/0 after the first step) → finishes at v=3/f=7, returns to IDLE for exactly 1 cycle, then sequences down to 0/0; other domains unaffected.
- Async reset asserted mid-V_WAIT → outputs return to reset values immediately, before the next clk edge.
